mul_sequencer: RTL and testbench
================================

# mul_sequencer

Multi-cycle shift-add multiplier sequencer for the EX stage. When the ALU controller selects MUL (ALUCtrl 4'b0101), this block latches the operands, holds the pipeline with a stall, iterates one partial product per cycle, and then presents the low WIDTH bits of the product for write-back. All other ALU operations pass through untouched; this block stays idle for them.

## Interface

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- ALUCtrl_i  input  4  ALU control code from the ALU controller; 4'b0101 = MUL.
- valid_i  input  1  EX-stage instruction is valid (not a bubble).
- flush_i  input  1  EX-stage instruction is squashed; aborts any multiply in progress.
- src1_i  input  WIDTH  multiplicand (rs).
- src2_i  input  WIDTH  multiplier (rt).
- stall_o  output  1  freezes PC, IF/ID and ID/EX while high.
- done_o  output  1  one-cycle pulse; result_o is valid this cycle.
- result_o  output  WIDTH  low WIDTH bits of the last completed product.
- busy_o  output  1  FSM is in RUN.

## Operation

- State machine with three states: IDLE, RUN and DONE. The encoding is free.
- start = valid_i & (ALUCtrl_i == 4'b0101) & ~flush_i.
- IDLE:
  - If start: latch mcand <= src1_i, mplier <= src2_i, acc <= 0, cnt <= 0. Go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per cycle:
  - If mplier[0] is 1: acc <= acc + mcand (mod 2^WIDTH).
  - Then mcand <= mcand << 1, mplier <= mplier >> 1 (logical), cnt <= cnt + 1.
  - When cnt == WIDTH-1, the iteration completes and the next state is DONE.
  - There is no early termination. The iteration count is fixed regardless of operand values.
- DONE:
  - result_o <= final acc, captured on entry to DONE.
  - done_o = 1 and stall_o = 0, so the stalled MUL advances at the end of this cycle.
  - start is ignored in DONE, because the instruction in EX is still the same MUL. Next state is always IDLE.
- Arithmetic: the product is taken modulo 2^WIDTH. The low half is identical for signed and unsigned operands, so no sign handling is needed.
- stall_o = (IDLE & start) | RUN, and is forced to 0 whenever flush_i = 1.
- flush_i in any state: next state IDLE, done_o not asserted, result_o unchanged.
- result_o holds its value until the next DONE. It is not cleared by IDLE or by a flush.
- Reset values: state = IDLE, stall_o = 0, done_o = 0, busy_o = 0, result_o = 0, internal registers = 0.

## Timing

- Cycle 0: MUL is in EX with valid_i = 1. stall_o = 1 combinationally and operands are latched at the edge.
- Cycles 1..WIDTH: RUN with stall_o = 1 and busy_o = 1.
- Cycle WIDTH+1: DONE with done_o = 1, result_o valid and stall_o = 0.
- Total stall: WIDTH+1 cycles (33 at the default). The MUL leaves EX at the end of cycle WIDTH+1.
- Back-to-back MULs: the second MUL is seen in IDLE at cycle WIDTH+2 and starts then. There is no overlap.
- src1_i and src2_i are sampled only in IDLE on start. Changes during RUN are ignored.
- Reset asserted mid-RUN: immediate return to IDLE and all outputs at reset values, with no clock edge required. After release, a fresh start is required.
- flush_i and start in the same cycle: flush wins and no start occurs.

## Test plan

- src1 = 7, src2 = 6, ALUCtrl = 0101, valid = 1:
  - stall_o high for exactly 33 cycles.
  - done_o pulses at cycle 33.
  - result_o = 42 and holds afterwards.
- src1 = 32'hFFFFFFFF, src2 = 32'hFFFFFFFF → result_o = 32'h00000001.
- src1 = 32'hFFFFFFFD (-3), src2 = 5 → result_o = 32'hFFFFFFF1 (-15).
- ALUCtrl = 0010 (ADD) and 0110 (SUB) with valid = 1, and MUL with valid = 0:
  - stall_o, busy_o and done_o stay 0.
  - result_o is unchanged.
- Start 7×6, then assert flush_i at cycle 10:
  - stall_o drops at cycle 10 and the FSM is in IDLE at cycle 11.
  - done_o is never pulsed and result_o keeps its previous value.
  - A new 3×4 then yields 12.
- Start a MUL, drive rst_i = 0 at cycle 5 mid-cycle:
  - Outputs go to 0 asynchronously.
- Back-to-back MULs 2×3 then 4×5:
  - done_o pulses at cycles 33 and 67.
  - result_o = 6, then 20.

Source files
------------

// File: rtl/mul_sequencer_if.sv
// EX-stage handshake bundle between the pipeline and the multiply sequencer.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       ALUCtrl_i;
  logic             valid_i;
  logic             flush_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             busy_o;

  modport master (
    output ALUCtrl_i, valid_i, flush_i,
    output src1_i, src2_i,
    input  stall_o, done_o, result_o, busy_o
  );

  modport slave (
    input  ALUCtrl_i, valid_i, flush_i,
    input  src1_i, src2_i,
    output stall_o, done_o, result_o, busy_o
  );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-add multiplier for EX: stalls the pipe for WIDTH+1 cycles per MUL
// and returns the low WIDTH bits of the product.
module mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk_i,
  input logic           rst_i,
  mul_sequencer_if.slave bus
);
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic             start;
  logic             idle;

  assign start = bus.valid_i & (bus.ALUCtrl_i == OP_MUL)
               & ~bus.flush_i;
  assign idle  = (state == IDLE);

  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush_i) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              mcand  <= bus.src1_i;
              mplier <= bus.src2_i;
              acc    <= '0;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= RUN;
            end
          end
          RUN: begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              result_q <= acc_nxt;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state    <= DONE;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Squash and reset both mask the pipeline-facing strobes immediately.
  assign bus.stall_o  = rst_i & ~bus.flush_i
                      & ((idle & start) | busy_q);
  assign bus.done_o   = done_q & ~bus.flush_i;
  assign bus.busy_o   = busy_q;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: vector table plus flush,
// reset and back-to-back sequences.
module tb_mul_sequencer;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  logic clk_i;
  logic rst_i;
  int   checks;
  int   failures;
  logic [31:0] last_result;

  mul_sequencer_if #(.WIDTH(32)) bus ();

  mul_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    logic [3:0] ctrl;
    logic       valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ALUCtrl_i = OP_ADD;
    bus.valid_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.src1_i    = '0;
    bus.src2_i    = '0;
  endtask

  // Called at posedge+1: that cycle is cycle 0 of the MUL.
  task automatic run_mul(input string name, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int stall_n;
    int busy_n;
    int done_n;
    int done_at;
    logic [31:0] res_at_done;
    stall_n = 0; busy_n = 0; done_n = 0; done_at = -1;
    res_at_done = 'x;
    bus.src1_i = a;
    bus.src2_i = b;
    bus.ALUCtrl_i = OP_MUL;
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (bus.stall_o) stall_n++;
      if (bus.busy_o) busy_n++;
      if (bus.done_o) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c;
          res_at_done = bus.result_o;
        end
      end
      @(posedge clk_i); #1;
      // Operand changes while running must not matter.
      if (c == 3) begin
        bus.src1_i = a ^ 32'h5A5A_1234;
        bus.src2_i = b ^ 32'h0F0F_0F0F;
      end
      if (done_at == c) idle_inputs();
    end
    chk({name, " stall_cycles"}, 32'(stall_n), 32'd33);
    chk({name, " busy_cycles"}, 32'(busy_n), 32'd32);
    chk({name, " done_count"}, 32'(done_n), 32'd1);
    chk({name, " done_cycle"}, 32'(done_at), 32'd33);
    chk({name, " result_at_done"}, res_at_done, exp);
    chk({name, " result_hold"}, bus.result_o, exp);
    last_result = exp;
  endtask

  task automatic run_other(input vec_t v);
    logic any;
    any = 1'b0;
    bus.ALUCtrl_i = v.ctrl;
    bus.valid_i = v.valid;
    bus.flush_i = 1'b0;
    bus.src1_i = v.a;
    bus.src2_i = v.b;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      any = any | bus.stall_o | bus.busy_o | bus.done_o;
      @(posedge clk_i); #1;
    end
    idle_inputs();
    chk({v.name, " no_activity"}, {31'd0, any}, 32'd0);
    chk({v.name, " result_kept"}, bus.result_o, last_result);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    last_result = '0;
    vecs[0] = '{"mul_7x6", OP_MUL, 1'b1, 32'd7, 32'd6, 32'd42};
    vecs[1] = '{"add", OP_ADD, 1'b1, 32'd9, 32'd9, 32'd0};
    vecs[2] = '{"mul_ones", OP_MUL, 1'b1, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 32'h0000_0001};
    vecs[3] = '{"sub", OP_SUB, 1'b1, 32'd3, 32'd1, 32'd0};
    vecs[4] = '{"mul_neg3x5", OP_MUL, 1'b1, 32'hFFFF_FFFD,
                32'd5, 32'hFFFF_FFF1};
    vecs[5] = '{"mul_bubble", OP_MUL, 1'b0, 32'd2, 32'd2, 32'd0};
    vecs[6] = '{"mul_10001sq", OP_MUL, 1'b1, 32'h0001_0001,
                32'h0001_0001, 32'h0002_0001};
    vecs[7] = '{"mul_by0", OP_MUL, 1'b1, 32'h1234_5678,
                32'd0, 32'd0};
    vecs[8] = '{"mul_msb", OP_MUL, 1'b1, 32'h8000_0001,
                32'd3, 32'h8000_0003};

    idle_inputs();
    rst_i = 1'b0;
    #8;
    chk("reset stall", {31'd0, bus.stall_o}, 32'd0);
    chk("reset busy", {31'd0, bus.busy_o}, 32'd0);
    chk("reset done", {31'd0, bus.done_o}, 32'd0);
    chk("reset result", bus.result_o, 32'd0);
    #4 rst_i = 1'b1;
    @(posedge clk_i); #1;

    foreach (vecs[i]) begin
      if (vecs[i].ctrl == OP_MUL && vecs[i].valid)
        run_mul(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp);
      else
        run_other(vecs[i]);
    end

    // Flush at cycle 10 of a 7x6.
    begin
      logic dn;
      dn = 1'b0;
      bus.src1_i = 32'd7;
      bus.src2_i = 32'd6;
      bus.ALUCtrl_i = OP_MUL;
      bus.valid_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk_i);
        dn = dn | bus.done_o;
        @(posedge clk_i); #1;
      end
      bus.flush_i = 1'b1;
      @(negedge clk_i);
      chk("flush stall_c10", {31'd0, bus.stall_o}, 32'd0);
      dn = dn | bus.done_o;
      @(posedge clk_i); #1;
      idle_inputs();
      @(negedge clk_i);
      chk("flush busy_c11", {31'd0, bus.busy_o}, 32'd0);
      chk("flush stall_c11", {31'd0, bus.stall_o}, 32'd0);
      for (int c = 0; c < 30; c++) begin
        dn = dn | bus.done_o;
        @(negedge clk_i);
      end
      chk("flush no_done", {31'd0, dn}, 32'd0);
      chk("flush result_kept", bus.result_o, last_result);
      @(posedge clk_i); #1;
    end
    run_mul("mul_3x4", 32'd3, 32'd4, 32'd12);

    // Asynchronous reset in the middle of cycle 5.
    bus.src1_i = 32'd9;
    bus.src2_i = 32'd9;
    bus.ALUCtrl_i = OP_MUL;
    bus.valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
    end
    #2 rst_i = 1'b0;
    #1;
    chk("arst stall", {31'd0, bus.stall_o}, 32'd0);
    chk("arst busy", {31'd0, bus.busy_o}, 32'd0);
    chk("arst done", {31'd0, bus.done_o}, 32'd0);
    chk("arst result", bus.result_o, 32'd0);
    idle_inputs();
    @(negedge clk_i);
    rst_i = 1'b1;
    last_result = '0;
    repeat (3) @(negedge clk_i);
    chk("arst stays_idle", {31'd0, bus.busy_o}, 32'd0);
    @(posedge clk_i); #1;

    // Back-to-back 2x3 then 4x5 with the second held in EX.
    begin
      int d1;
      int d2;
      int dn;
      logic [31:0] r1;
      logic [31:0] r2;
      d1 = -1; d2 = -1; dn = 0; r1 = 'x; r2 = 'x;
      bus.src1_i = 32'd2;
      bus.src2_i = 32'd3;
      bus.ALUCtrl_i = OP_MUL;
      bus.valid_i = 1'b1;
      for (int c = 0; c < 75; c++) begin
        @(negedge clk_i);
        if (bus.done_o) begin
          dn++;
          if (d1 < 0) begin d1 = c; r1 = bus.result_o; end
          else if (d2 < 0) begin d2 = c; r2 = bus.result_o; end
        end
        @(posedge clk_i); #1;
        if (d1 == c) begin
          bus.src1_i = 32'd4;
          bus.src2_i = 32'd5;
        end
        if (d2 == c) idle_inputs();
      end
      chk("b2b done1_cycle", 32'(d1), 32'd33);
      chk("b2b done2_cycle", 32'(d2), 32'd67);
      chk("b2b done_count", 32'(dn), 32'd2);
      chk("b2b result1", r1, 32'd6);
      chk("b2b result2", r2, 32'd20);
      chk("b2b result_hold", bus.result_o, 32'd20);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
